// File: rtl/series_seq_ctrl_if.sv
// series_seq_ctrl_if: handshake bundle between the series sequencer and its div/mul/add datapath units.
// Revision 1.0
`default_nettype none

interface series_seq_ctrl_if #(
  parameter int CNT_W   = 5,
  parameter int NUM_MUL = 2
);
  logic               start;
  logic [CNT_W-1:0]   iter_n;
  logic               abort;
  logic               div_done;
  logic [NUM_MUL-1:0] mul_done;
  logic               load_en;
  logic               div_en;
  logic [NUM_MUL-1:0] mul_en;
  logic               add_en;
  logic [CNT_W-1:0]   iter;
  logic [3:0]         state;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output start, iter_n, abort, div_done, mul_done,
    input  load_en, div_en, mul_en, add_en, iter, state, busy, done, err
  );

  modport slave (
    input  start, iter_n, abort, div_done, mul_done,
    output load_en, div_en, mul_en, add_en, iter, state, busy, done, err
  );
endinterface

`default_nettype wire

// File: rtl/series_seq_ctrl.sv
// series_seq_ctrl: iterative series controller (LOAD, DEC, DIV, NUM_MUL x MUL, ADD, CMP per term).
// Optional watchdog on DIV/MUL waits enabled by SERIES_SEQ_WATCHDOG_EN. Revision 1.0
`default_nettype none

module series_seq_ctrl #(
  parameter int CNT_W    = 5,
  parameter int NUM_MUL  = 2,
  parameter int WD_W     = 8,
  parameter int WD_LIMIT = 255
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  series_seq_ctrl_if.slave   bus
);

  localparam int c_MIDX_W = (NUM_MUL > 1) ? $clog2(NUM_MUL) : 1;
  localparam logic [c_MIDX_W-1:0] c_LAST_IDX = c_MIDX_W'(NUM_MUL - 1);

  localparam logic [3:0] c_S_IDLE = 4'd0;
  localparam logic [3:0] c_S_LOAD = 4'd1;
  localparam logic [3:0] c_S_DEC  = 4'd2;
  localparam logic [3:0] c_S_DIV  = 4'd3;
  localparam logic [3:0] c_S_MUL  = 4'd4;
  localparam logic [3:0] c_S_ADD  = 4'd5;
  localparam logic [3:0] c_S_CMP  = 4'd6;
  localparam logic [3:0] c_S_DONE = 4'd7;
`ifdef SERIES_SEQ_WATCHDOG_EN
  localparam logic [3:0] c_S_ERR  = 4'd8;
  localparam logic [WD_W-1:0] c_WD_LAST = WD_W'(WD_LIMIT - 1);
`endif

  if (NUM_MUL < 1 || NUM_MUL > 4) begin : g_bad_num_mul
    $error("series_seq_ctrl: NUM_MUL must be 1..4");
  end
  if (WD_LIMIT < 1 || WD_LIMIT >= (2 ** WD_W)) begin : g_bad_wd_limit
    $error("series_seq_ctrl: WD_LIMIT must be 1..2**WD_W-1");
  end

  logic [3:0]          r_state;
  logic [CNT_W-1:0]    r_iter;
  logic [c_MIDX_W-1:0] r_mul_idx;

  logic [3:0]          w_next_state;
  logic [CNT_W-1:0]    w_next_iter;
  logic [c_MIDX_W-1:0] w_next_mul_idx;
  logic                w_run_state;
  logic                w_wd_expired;

  logic                w_load_en;
  logic                w_div_en;
  logic [NUM_MUL-1:0]  w_mul_en;
  logic                w_add_en;
  logic                w_busy;
  logic                w_done;
  logic                w_err;

  assign w_run_state = (r_state >= c_S_LOAD) && (r_state <= c_S_CMP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_S_IDLE;
      r_iter    <= '0;
      r_mul_idx <= '0;
    end else begin
      r_state   <= w_next_state;
      r_iter    <= w_next_iter;
      r_mul_idx <= w_next_mul_idx;
    end
  end

`ifdef SERIES_SEQ_WATCHDOG_EN
  logic [WD_W-1:0] r_wd;

  // Any state or stage change restarts the wait count, so each unit gets a full budget.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd <= '0;
    end else if ((w_next_state != r_state) || (w_next_mul_idx != r_mul_idx)) begin
      r_wd <= '0;
    end else if ((r_state == c_S_DIV) || (r_state == c_S_MUL)) begin
      r_wd <= r_wd + 1'b1;
    end
  end

  assign w_wd_expired = (r_wd == c_WD_LAST);
`else
  assign w_wd_expired = 1'b0;
`endif

  always_comb begin
    w_next_state   = r_state;
    w_next_iter    = r_iter;
    w_next_mul_idx = r_mul_idx;
    case (r_state)
      c_S_IDLE: begin
        if (bus.start) begin
          w_next_state = c_S_LOAD;
          w_next_iter  = bus.iter_n;
        end
      end
      c_S_LOAD: w_next_state = c_S_DEC;
      c_S_DEC: begin
        if (r_iter == '0) begin
          w_next_state = c_S_DONE;
        end else begin
          w_next_iter  = r_iter - 1'b1;
          w_next_state = c_S_DIV;
        end
      end
      c_S_DIV: begin
        if (bus.div_done) begin
          w_next_state   = c_S_MUL;
          w_next_mul_idx = '0;
        end else if (w_wd_expired) begin
`ifdef SERIES_SEQ_WATCHDOG_EN
          w_next_state = c_S_ERR;
`endif
        end
      end
      c_S_MUL: begin
        if (bus.mul_done[r_mul_idx]) begin
          if (r_mul_idx == c_LAST_IDX) begin
            w_next_state = c_S_ADD;
          end else begin
            w_next_mul_idx = r_mul_idx + 1'b1;
          end
        end else if (w_wd_expired) begin
`ifdef SERIES_SEQ_WATCHDOG_EN
          w_next_state = c_S_ERR;
`endif
        end
      end
      c_S_ADD:  w_next_state = c_S_CMP;
      c_S_CMP:  w_next_state = (r_iter != '0) ? c_S_DEC : c_S_DONE;
      c_S_DONE: w_next_state = c_S_IDLE;
`ifdef SERIES_SEQ_WATCHDOG_EN
      c_S_ERR: begin
        if (bus.abort) begin
          w_next_state = c_S_IDLE;
        end
      end
`endif
      default:  w_next_state = c_S_IDLE;
    endcase

    // Abort overrides any same-cycle done input and leaves the counter untouched.
    if (bus.abort && w_run_state) begin
      w_next_state   = c_S_IDLE;
      w_next_iter    = r_iter;
      w_next_mul_idx = '0;
    end
  end

  always_comb begin
    w_load_en = 1'b0;
    w_div_en  = 1'b0;
    w_mul_en  = '0;
    w_add_en  = 1'b0;
    w_done    = 1'b0;
    w_err     = 1'b0;
    w_busy    = w_run_state;
    case (r_state)
      c_S_LOAD: w_load_en = 1'b1;
      c_S_DIV:  w_div_en  = 1'b1;
      c_S_MUL:  w_mul_en  = NUM_MUL'(1) << r_mul_idx;
      c_S_ADD:  w_add_en  = 1'b1;
      c_S_DONE: w_done    = 1'b1;
`ifdef SERIES_SEQ_WATCHDOG_EN
      c_S_ERR:  w_err     = 1'b1;
`endif
      default:  ;
    endcase
  end

  assign bus.load_en = w_load_en;
  assign bus.div_en  = w_div_en;
  assign bus.mul_en  = w_mul_en;
  assign bus.add_en  = w_add_en;
  assign bus.busy    = w_busy;
  assign bus.done    = w_done;
  assign bus.err     = w_err;
  assign bus.state   = r_state;
  assign bus.iter    = r_iter;

endmodule

`default_nettype wire

// File: tb/tb_series_seq_ctrl.sv
// tb_series_seq_ctrl: directed checks of the series sequencer (default NUM_MUL=2, CNT_W=5).
// Revision 1.0
`default_nettype none

module tb_series_seq_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  series_seq_ctrl_if #(.CNT_W(5), .NUM_MUL(2)) bus ();

  series_seq_ctrl #(
    .CNT_W(5), .NUM_MUL(2), .WD_W(8), .WD_LIMIT(255)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.start    = 1'b0;
    bus.iter_n   = '0;
    bus.abort    = 1'b0;
    bus.div_done = 1'b0;
    bus.mul_done = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (3) step();
    checks++;
    if (bus.state !== 4'd0 || bus.iter !== 5'd0) begin
      failures++;
      $display("FAIL reset_state: state=%0d iter=%0d, want 0/0", bus.state, bus.iter);
    end
    checks++;
    if ({bus.load_en, bus.div_en, bus.mul_en, bus.add_en, bus.busy, bus.done, bus.err} !== 8'd0) begin
      failures++;
      $display("FAIL reset_outputs: load=%b div=%b mul=%b add=%b busy=%b done=%b err=%b, want all 0",
               bus.load_en, bus.div_en, bus.mul_en, bus.add_en, bus.busy, bus.done, bus.err);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_zero_iter();
    logic [3:0] exp_state [1:4];
    int         en_seen;
    exp_state[1] = 4'd1; exp_state[2] = 4'd2; exp_state[3] = 4'd7; exp_state[4] = 4'd0;
    en_seen = 0;
    bus.start  = 1'b1;
    bus.iter_n = 5'd0;
    for (int c = 1; c <= 4; c++) begin
      step();
      bus.start = 1'b0;
      if (bus.div_en || bus.mul_en != 2'b00 || bus.add_en) en_seen++;
      checks++;
      if (bus.state !== exp_state[c] || bus.load_en !== (c == 1) || bus.done !== (c == 3)) begin
        failures++;
        $display("FAIL zero_iter_c%0d: state=%0d load=%b done=%b, want %0d/%b/%b",
                 c, bus.state, bus.load_en, bus.done, exp_state[c], (c == 1), (c == 3));
      end
    end
    checks++;
    if (en_seen !== 0) begin
      failures++;
      $display("FAIL zero_iter_enables: %0d cycles with unit enables, want 0", en_seen);
    end
  endtask

  task automatic test_series();
    int n_div, n_m0, n_m1, n_add, done_cyc, bad_order;
    logic [1:0] prev_mul;
    n_div = 0; n_m0 = 0; n_m1 = 0; n_add = 0; done_cyc = -1; bad_order = 0;
    prev_mul = 2'b00;
    bus.start  = 1'b1;
    bus.iter_n = 5'd3;
    for (int c = 1; c <= 24; c++) begin
      step();
      bus.start = 1'b0;
      if (bus.div_en) n_div++;
      if (bus.mul_en == 2'b01) n_m0++;
      if (bus.mul_en == 2'b10) begin
        n_m1++;
        if (prev_mul != 2'b01) bad_order++;
      end
      if (bus.add_en) n_add++;
      if (bus.done && done_cyc < 0) done_cyc = c;
      if (c == 3) begin
        checks++;
        if (bus.iter !== 5'd2 || bus.state !== 4'd3) begin
          failures++;
          $display("FAIL series_first_div: state=%0d iter=%0d, want 3/2", bus.state, bus.iter);
        end
      end
      prev_mul     = bus.mul_en;
      bus.div_done = bus.div_en;
      bus.mul_done = bus.mul_en;
    end
    clear_inputs();
    checks++;
    if (n_div !== 3 || n_add !== 3) begin
      failures++;
      $display("FAIL series_div_add: div=%0d add=%0d, want 3/3", n_div, n_add);
    end
    checks++;
    if (n_m0 !== 3 || n_m1 !== 3 || bad_order !== 0) begin
      failures++;
      $display("FAIL series_mul: m0=%0d m1=%0d bad_order=%0d, want 3/3/0", n_m0, n_m1, bad_order);
    end
    checks++;
    if (done_cyc !== 20 || bus.iter !== 5'd0 || bus.state !== 4'd0) begin
      failures++;
      $display("FAIL series_done: done_cycle=%0d iter=%0d state=%0d, want 20/0/0",
               done_cyc, bus.iter, bus.state);
    end
  endtask

  task automatic test_div_wait();
    int n_div, n_mul, early_mul, done_cyc;
    n_div = 0; n_mul = 0; early_mul = 0; done_cyc = -1;
    bus.start    = 1'b1;
    bus.iter_n   = 5'd1;
    bus.mul_done = 2'b11;
    for (int c = 1; c <= 22; c++) begin
      step();
      bus.start = 1'b0;
      if (bus.div_en) n_div++;
      if (bus.state == 4'd4) begin
        n_mul++;
        if (n_div < 11) early_mul++;
      end
      if (bus.done && done_cyc < 0) done_cyc = c;
      bus.div_done = bus.div_en && (n_div == 11);
    end
    clear_inputs();
    checks++;
    if (n_div !== 11 || early_mul !== 0) begin
      failures++;
      $display("FAIL div_wait_div: div_en cycles=%0d early_mul=%0d, want 11/0", n_div, early_mul);
    end
    checks++;
    if (n_mul !== 2 || done_cyc !== 18) begin
      failures++;
      $display("FAIL div_wait_mul: mul cycles=%0d done_cycle=%0d, want 2/18", n_mul, done_cyc);
    end
  endtask

  task automatic test_abort();
    int found, n_done;
    found = 0; n_done = 0;
    bus.start  = 1'b1;
    bus.iter_n = 5'd2;
    for (int c = 1; c <= 20 && found == 0; c++) begin
      step();
      bus.start = 1'b0;
      if (bus.state == 4'd4 && bus.mul_en == 2'b10) begin
        found = 1;
      end else begin
        bus.div_done = bus.div_en;
        bus.mul_done = bus.mul_en;
      end
    end
    checks++;
    if (found !== 1) begin
      failures++;
      $display("FAIL abort_reach_mul1: reached=%0d, want 1", found);
    end
    bus.abort    = 1'b1;
    bus.mul_done = 2'b10;
    bus.div_done = 1'b0;
    step();
    clear_inputs();
    checks++;
    if (bus.state !== 4'd0 || bus.busy !== 1'b0 || bus.iter !== 5'd1 ||
        {bus.load_en, bus.div_en, bus.mul_en, bus.add_en, bus.done} !== 6'd0) begin
      failures++;
      $display("FAIL abort_mul: state=%0d busy=%b iter=%0d mul=%b done=%b, want 0/0/1/00/0",
               bus.state, bus.busy, bus.iter, bus.mul_en, bus.done);
    end
    for (int c = 0; c < 5; c++) begin
      step();
      if (bus.done) n_done++;
    end
    checks++;
    if (n_done !== 0 || bus.state !== 4'd0) begin
      failures++;
      $display("FAIL abort_no_done: done cycles=%0d state=%0d, want 0/0", n_done, bus.state);
    end
    // abort held in IDLE must not block a start
    bus.abort  = 1'b1;
    bus.start  = 1'b1;
    bus.iter_n = 5'd0;
    step();
    clear_inputs();
    checks++;
    if (bus.state !== 4'd1) begin
      failures++;
      $display("FAIL abort_idle: state=%0d, want 1", bus.state);
    end
    repeat (3) step();
  endtask

  task automatic test_watchdog();
    int n_div;
    n_div = 0;
    bus.start  = 1'b1;
    bus.iter_n = 5'd1;
    for (int c = 1; c <= 300; c++) begin
      step();
      bus.start = 1'b0;
      if (bus.div_en) n_div++;
    end
    checks++;
`ifdef SERIES_SEQ_WATCHDOG_EN
    if (n_div !== 255 || bus.state !== 4'd8 || bus.err !== 1'b1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL watchdog_trip: div cycles=%0d state=%0d err=%b busy=%b, want 255/8/1/0",
               n_div, bus.state, bus.err, bus.busy);
    end
`else
    if (n_div !== 298 || bus.state !== 4'd3 || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL watchdog_off: div cycles=%0d state=%0d err=%b, want 298/3/0",
               n_div, bus.state, bus.err);
    end
`endif
    bus.abort = 1'b1;
    step();
    clear_inputs();
    checks++;
    if (bus.state !== 4'd0 || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL watchdog_abort: state=%0d err=%b, want 0/0", bus.state, bus.err);
    end
  endtask

  task automatic test_reset_mid();
    int found, done_cyc;
    found = 0; done_cyc = -1;
    bus.start  = 1'b1;
    bus.iter_n = 5'd2;
    for (int c = 1; c <= 20 && found == 0; c++) begin
      step();
      bus.start = 1'b0;
      if (bus.state == 4'd4) found = 1;
      bus.div_done = bus.div_en;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (found !== 1 || bus.state !== 4'd0 || bus.iter !== 5'd0 ||
        {bus.load_en, bus.div_en, bus.mul_en, bus.add_en, bus.busy, bus.done, bus.err} !== 8'd0) begin
      failures++;
      $display("FAIL reset_mid: reached=%0d state=%0d iter=%0d mul=%b busy=%b, want 1/0/0/00/0",
               found, bus.state, bus.iter, bus.mul_en, bus.busy);
    end
    clear_inputs();
    repeat (2) step();
    rst_n = 1'b1;
    step();
    bus.start  = 1'b1;
    bus.iter_n = 5'd1;
    for (int c = 1; c <= 10; c++) begin
      step();
      bus.start = 1'b0;
      if (bus.done && done_cyc < 0) done_cyc = c;
      bus.div_done = bus.div_en;
      bus.mul_done = bus.mul_en;
    end
    clear_inputs();
    checks++;
    if (done_cyc !== 8 || bus.iter !== 5'd0 || bus.state !== 4'd0) begin
      failures++;
      $display("FAIL reset_restart: done_cycle=%0d iter=%0d state=%0d, want 8/0/0",
               done_cyc, bus.iter, bus.state);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_zero_iter();
    test_series();
    test_div_wait();
    test_abort();
    test_watchdog();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
